// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX serializer between NUM_REQ byte sources
// using round-robin arbitration, launches each captured byte, waits for the
// end of frame and inserts IDLE_GAP idle bit-clocks before the next grant.
// Optional: define UART_ARB_LOCK_EN to add the lock port for multi-byte bursts.
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int ID_W     = 2,
    parameter int IDLE_GAP = 1
) (
    input  logic                      bclk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] din,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock,
`endif
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [ID_W-1:0]           cur_id
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_e;

    // Last gap-counter value; with IDLE_GAP = 0 the GAP state is never entered.
    localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);
    localparam logic [ID_W-1:0] ID_RESET = ID_W'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic [3:0]          gap_cnt_q, gap_cnt_d;
`ifdef UART_ARB_LOCK_EN
    logic                lock_pend_q, lock_pend_d;
`endif

    logic                rr_found;
    logic [ID_W-1:0]     rr_id;
    logic                win_valid;
    logic [ID_W-1:0]     win_id;

    // Round-robin search: first requester after cur_id, wrapping, cur_id last.
    always_comb begin
        rr_found = 1'b0;
        rr_id    = cur_id_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!rr_found && req[(int'(cur_id_q) + k) % NUM_REQ]) begin
                rr_found = 1'b1;
                rr_id    = ID_W'((int'(cur_id_q) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        gnt_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        cur_id_d   = cur_id_q;
        gap_cnt_d  = gap_cnt_q;
        win_valid  = rr_found;
        win_id     = rr_id;
`ifdef UART_ARB_LOCK_EN
        lock_pend_d = lock_pend_q;
        // A locked burst owner that is still requesting bypasses round-robin.
        if (lock_pend_q && req[cur_id_q]) begin
            win_valid = 1'b1;
            win_id    = cur_id_q;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (win_valid && !tx_busy) begin
                    state_d        = S_GRANT;
                    tx_data_d      = din[int'(win_id)*DATA_W +: DATA_W];
                    cur_id_d       = win_id;
                    gnt_d[win_id]  = 1'b1;
`ifdef UART_ARB_LOCK_EN
                    lock_pend_d    = 1'b0;
`endif
                end
            end
            S_GRANT: begin
                state_d    = S_LAUNCH;
                tx_start_d = 1'b1;
            end
            S_LAUNCH, S_WAIT_DONE: begin
                if (tx_done) begin
                    if (IDLE_GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
`ifdef UART_ARB_LOCK_EN
                    lock_pend_d = lock[cur_id_q] && req[cur_id_q];
`endif
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge bclk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            cur_id_q    <= ID_RESET;
            gap_cnt_q   <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            cur_id_q    <= cur_id_d;
            gap_cnt_q   <= gap_cnt_d;
`ifdef UART_ARB_LOCK_EN
            lock_pend_q <= lock_pend_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign cur_id   = cur_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter (default parameters)
// with a small behavioural serializer that ends each frame FRAME_LEN cycles
// after it sees tx_start. The lock scenario runs when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int ID_W      = 2;
    localparam int FRAME_LEN = 10;
    localparam int WAIT_MAX  = 40;

    logic                      bclk = 1'b0;
    logic                      rst  = 1'b1;
    logic [NUM_REQ-1:0]        req  = '0;
    logic [NUM_REQ*DATA_W-1:0] din  = '0;
`ifdef UART_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        lock = '0;
`endif
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic                      tx_done = 1'b0;
    logic                      busy;
    logic [ID_W-1:0]           cur_id;

    logic                      ser_busy   = 1'b0;
    logic                      force_busy = 1'b0;
    int                        ser_cnt    = 0;

    int checks = 0;
    int errors = 0;

    int rr_ids[5]  = '{0, 1, 2, 3, 0};
    int alt_ids[4] = '{2, 0, 2, 0};

    assign tx_busy = ser_busy | force_busy;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ID_W    (ID_W),
        .IDLE_GAP(1)
    ) dut (
        .bclk    (bclk),
        .rst     (rst),
        .req     (req),
        .din     (din),
`ifdef UART_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .busy    (busy),
        .cur_id  (cur_id)
    );

    always #5 bclk = ~bclk;

    // Serializer model: updates 1 ns after the falling edge so the main
    // sequence, which samples exactly on the falling edge, sees a stable value.
    always @(negedge bclk) begin
        #1;
        if (rst) begin
            ser_busy = 1'b0;
            tx_done  = 1'b0;
            ser_cnt  = 0;
        end else begin
            tx_done = 1'b0;
            if (ser_busy) begin
                ser_cnt = ser_cnt - 1;
                if (ser_cnt == 0) begin
                    tx_done  = 1'b1;
                    ser_busy = 1'b0;
                end
            end else if (tx_start) begin
                ser_busy = 1'b1;
                ser_cnt  = FRAME_LEN;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // NOTE: outputs are sampled on the falling edge, away from the active rising edge.
    task automatic tick();
        @(negedge bclk);
    endtask

    // Wait (bounded) for a grant pulse, then check which requester won and what was captured.
    task automatic grant_chk(input int id, input logic [7:0] data, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (gnt == '0 && waited < WAIT_MAX);
        check("gnt_seen", 32'(|gnt), 32'd1);
        check("gnt_onehot", 32'(gnt), 32'd1 << id);
        check("cur_id", 32'(cur_id), 32'(id));
        check("tx_data_cap", 32'(tx_data), 32'(data));
        check("no_start_with_gnt", 32'(tx_start), 32'd0);
        check("busy_in_grant", 32'(busy), 32'd1);
    endtask

    // Follow the launch, the frame and the gap back to IDLE.
    task automatic finish_frame(input logic [7:0] data);
        int n;
        tick();
        check("tx_start_pulse", 32'(tx_start), 32'd1);
        check("gnt_single_cycle", 32'(gnt), 32'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_done && n < WAIT_MAX);
        check("done_seen", 32'(tx_done), 32'd1);
        check("tx_data_held", 32'(tx_data), 32'(data));
        check("busy_in_gap", 32'(busy), 32'd1);
        check("no_gnt_in_gap", 32'(gnt), 32'd0);
        tick();
        check("busy_released", 32'(busy), 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int w;

        // Reset state.
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_id", 32'(cur_id), 32'd3);
        tick();
        rst = 1'b0;

        // Single requester, grant latency of one cycle.
        din = 32'h0000_00A5;
        req = 4'b0001;
        grant_chk(0, 8'hA5, w);
        check("first_latency", 32'(w), 32'd1);
        req = 4'b0000;
        finish_frame(8'hA5);
        tick();
        check("idle_no_req", 32'(busy), 32'd0);

        // All requesters active: strict rotation starting at 0 after reset.
        apply_reset();
        din = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            grant_chk(rr_ids[i], 8'h10 + 8'(rr_ids[i]), w);
            if (i > 0) check("rr_spacing", 32'(w), 32'd1);
            finish_frame(8'h10 + 8'(rr_ids[i]));
        end

        // Requesters 0 and 2 alternate.
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            grant_chk(alt_ids[i], 8'h10 + 8'(alt_ids[i]), w);
            finish_frame(8'h10 + 8'(alt_ids[i]));
        end

        // Serializer busy in IDLE blocks arbitration.
        req        = 4'b0010;
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("blocked_gnt", 32'(gnt), 32'd0);
            check("blocked_busy", 32'(busy), 32'd0);
        end
        force_busy = 1'b0;
        grant_chk(1, 8'h11, w);
        check("unblock_latency", 32'(w), 32'd1);
        req = 4'b0000;
        finish_frame(8'h11);

        // Asynchronous reset in WAIT_DONE.
        req = 4'b0100;
        grant_chk(2, 8'h12, w);
        req = 4'b0000;
        tick();
        tick();
        check("wait_done_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_tx_start", 32'(tx_start), 32'd0);
        check("async_cur_id", 32'(cur_id), 32'd3);
        check("async_tx_data", 32'(tx_data), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        req = 4'b1001;
        grant_chk(0, 8'h10, w);
        check("post_rst_latency", 32'(w), 32'd1);
        req = 4'b0000;
        finish_frame(8'h10);

`ifdef UART_ARB_LOCK_EN
        // Locked burst: requester 0 keeps the serializer for three frames.
        apply_reset();
        lock = 4'b0001;
        req  = 4'b0011;
        grant_chk(0, 8'h10, w);
        finish_frame(8'h10);
        grant_chk(0, 8'h10, w);
        finish_frame(8'h10);
        grant_chk(0, 8'h10, w);
        lock = 4'b0000;
        finish_frame(8'h10);
        grant_chk(1, 8'h11, w);
        req = 4'b0000;
        finish_frame(8'h11);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares a single UART transmit serializer between NUM_REQ byte sources. Arbitration is round-robin. The block captures the winning byte, launches the serializer, waits for frame completion, and enforces an inter-frame gap. It sits between the system-side producers and the TX shift module, and runs in the bit-clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width per requester
ID_W, 2, width of cur_id; must be >= clog2(NUM_REQ)
IDLE_GAP, 1, bclk cycles of idle line inserted after each frame (0..15)

Ports:
bclk  in  1  bit clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester transmit request, level
din  in  NUM_REQ*DATA_W  flat data bus; requester i on bits [i*DATA_W +: DATA_W]
gnt  out  NUM_REQ  one-hot, single-cycle acknowledge: byte captured
tx_data  out  DATA_W  byte presented to serializer, held stable until frame done
tx_start  out  1  single-cycle launch pulse to serializer
tx_busy  in  1  serializer busy level
tx_done  in  1  serializer single-cycle end-of-frame pulse
busy  out  1  high whenever state != IDLE
cur_id  out  ID_W  index of current/last granted requester

Behaviour:
- Reset values: gnt=0, tx_start=0, tx_data=0, busy=0, cur_id=NUM_REQ-1, state=IDLE, gap counter=0. Because cur_id starts at NUM_REQ-1, requester 0 has top priority after reset.
- All outputs are registered. Reset is asynchronous and takes effect mid-frame. The serializer is reset by the same rst.
- States: IDLE, GRANT, LAUNCH, WAIT_DONE, GAP.
- IDLE -> GRANT when |req and !tx_busy.
  - Winner: first i with req[i]=1, searching cur_id+1, cur_id+2, ... modulo NUM_REQ.
  - On this edge: tx_data <= din[winner], cur_id <= winner, gnt[winner] <= 1.
- GRANT: gnt is high for exactly this one cycle, then GRANT -> LAUNCH with tx_start <= 1.
  - The requester may drop req or change din from the cycle after gnt.
- LAUNCH: tx_start is high for exactly one cycle, then -> WAIT_DONE.
  - A tx_done seen during LAUNCH is accepted and goes straight to GAP/IDLE.
- WAIT_DONE: hold tx_data. On tx_done: -> GAP if IDLE_GAP>0, else -> IDLE.
- GAP: counts IDLE_GAP cycles, then -> IDLE. No new grant is issued during the gap.
- Latency: req high in IDLE with tx_busy=0 gives gnt 1 cycle later and tx_start 2 cycles later.
- Requests arriving during GRANT..GAP are held by the requester (req is level). They are arbitrated on return to IDLE.
- A req dropped before being sampled in IDLE is never granted.
- A req retracted while another requester is being served is not granted.
- tx_busy high in IDLE blocks arbitration.
- tx_done outside LAUNCH/WAIT_DONE is ignored.
- Single active requester: it is re-granted every frame. Minimum spacing between its gnt pulses is 3+IDLE_GAP cycles plus the serializer frame time.
- At most one gnt bit is ever set. tx_start never coincides with gnt.

Optional Feature:
Macro UART_ARB_LOCK_EN.
- Defined:
  - Adds input port lock, width NUM_REQ.
  - If lock[cur_id] and req[cur_id] are both high when tx_done is accepted, the next grant goes to cur_id directly after the gap, bypassing round-robin. This is for multi-byte bursts.
  - Lock is ignored for the first grant out of reset.
- Not defined: the lock port is absent and arbitration is pure round-robin.

Test Plan:
- Reset, then req=4'b0001, din0=8'hA5, serializer asserts tx_done 10 cycles after tx_start -> gnt=0001 one cycle after req sampled; tx_start next cycle; tx_data=8'hA5 held until tx_done; busy returns to 0 after IDLE_GAP=1 cycle.
- req=4'b1111 held, din_i=8'h10+i -> tx_data sequence 10,11,12,13,10; gnt one-hot each time; cur_id 0,1,2,3,0.
- req=4'b0101 held after a grant to cur_id=2 -> next grant goes to requester 0, then 2, alternating.
- tx_busy=1 in IDLE with req=0010 -> no gnt while busy. Drop tx_busy -> gnt=0010 the next cycle.
- rst pulse during WAIT_DONE -> busy, gnt and tx_start drop immediately. The next grant with req=1001 goes to requester 0.
- UART_ARB_LOCK_EN, req=0011, lock=0001 for 3 frames -> requester 0 granted 3 times consecutively, then lock=0 hands the next grant to requester 1.
